// File: rtl/parity_if.sv
// parity_if: TX parity and RX parity-check signal bundle shared by the UART paths
interface parity_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  PAR_EN;
  logic [1:0]            PAR_TYP;
  logic                  DATA_VALID;
  logic                  BUSY;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_bit;
  logic                  CHK_START;
  logic                  SAMPLE_VALID;
  logic                  SAMPLED_BIT;
  logic                  CHK_DONE;
  logic                  PAR_ERR;
  modport master (
    output PAR_EN, PAR_TYP, DATA_VALID, BUSY, P_DATA, CHK_START, SAMPLE_VALID, SAMPLED_BIT,
    input  PAR_bit, CHK_DONE, PAR_ERR
  );
  modport slave (
    input  PAR_EN, PAR_TYP, DATA_VALID, BUSY, P_DATA, CHK_START, SAMPLE_VALID, SAMPLED_BIT,
    output PAR_bit, CHK_DONE, PAR_ERR
  );
endinterface

// File: rtl/parity_unit.sv
// parity_unit: registered TX parity generation plus bit-serial RX parity checker
module parity_unit #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input logic     CLK,
  input logic     RST,
  parity_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       typ_q, typ_d;
  logic             acc_q, acc_d, err_q, err_d, done_q, done_d, en_q, en_d, par_q, par_d;
  logic             last, step, fin;
  // CHK_START overrides any strobe in the same cycle
  assign last = cnt_q == CNT_W'(DATA_WIDTH - 1);
  assign step = bus.SAMPLE_VALID && !bus.CHK_START && state_q == DATA;
  assign fin  = bus.SAMPLE_VALID && !bus.CHK_START && state_q == PARITY;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      typ_q   <= 2'b00;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      typ_q   <= typ_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      en_q    <= en_d;
      par_q   <= par_d;
    end
  end
  always_comb
    state_d = bus.CHK_START ? DATA :
              step && last  ? (en_q ? PARITY : IDLE) :
              fin           ? IDLE : state_q;
  // Mark/space force the bit; even/odd fold the mode LSB into the XOR
  always_comb begin
    par_d  = bus.DATA_VALID && !bus.BUSY ?
             (bus.PAR_TYP[1] ? ~bus.PAR_TYP[0] : ^bus.P_DATA ^ bus.PAR_TYP[0]) : par_q;
    cnt_d  = bus.CHK_START ? '0 : step && !last ? cnt_q + 1'b1 : cnt_q;
    acc_d  = bus.CHK_START ? 1'b0 : step ? acc_q ^ bus.SAMPLED_BIT : acc_q;
    err_d  = bus.CHK_START ? 1'b0 :
             fin ? bus.SAMPLED_BIT != (typ_q[1] ? ~typ_q[0] : acc_q ^ typ_q[0]) : err_q;
    done_d = (step && last && !en_q) || fin;
    typ_d  = bus.CHK_START ? bus.PAR_TYP : typ_q;
    en_d   = bus.CHK_START ? bus.PAR_EN : en_q;
  end
  assign bus.PAR_bit  = par_q;
  assign bus.CHK_DONE = done_q;
  assign bus.PAR_ERR  = err_q;
endmodule
